// File: rtl/norm_seq_pkg.sv
// Shared types and constants for the I/Q normalizer sequencer.
// The optional drop counter is controlled by NORM_SEQ_DROP_CNT_EN (see norm_sequencer.sv).
package norm_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Normalizer timing contract, in edges after the norm_stb cycle.
  localparam int NORM_DATA_LAT = 4;
  localparam int NORM_TRIG_LAT = 5;

  localparam int NORM_IN_W  = 64;
  localparam int NORM_OUT_W = 36;

endpackage

// File: rtl/norm_seq_fifo.sv
// Synchronous FIFO for normalized I/Q results; head entry is read straight from the storage registers.
// DEPTH must be a power of two so the pointers wrap naturally.
module norm_seq_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 36
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  import norm_seq_pkg::*;

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Push while full is only legal together with a pop; the old head slot becomes the tail.
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

endmodule

// File: rtl/norm_sequencer.sv
// Feeds accumulated I/Q words to the normalizer one at a time and queues its results for the NN core.
// Define NORM_SEQ_DROP_CNT_EN to build the saturating timeout counter behind drop_cnt.
module norm_sequencer #(
  parameter int IN_W       = norm_seq_pkg::NORM_IN_W,
  parameter int OUT_W      = norm_seq_pkg::NORM_OUT_W,
  parameter int FIFO_DEPTH = 2,
  parameter int TRIG_TMO   = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  output logic             acc_ready,
  input  logic [IN_W-1:0]  acc_data,
  output logic [IN_W-1:0]  norm_acc_data,
  output logic             norm_stb,
  input  logic [OUT_W-1:0] norm_data,
  input  logic             norm_trig,
  output logic             nn_valid,
  input  logic             nn_ready,
  output logic [OUT_W-1:0] nn_data,
  output logic             busy,
  output logic             tmo_err,
  output logic [15:0]      drop_cnt
);
  import norm_seq_pkg::*;

  // Both ports are valid/ready: a word moves on a cycle where valid and ready are both high at the
  // rising edge; valid never waits on ready, and the head data is held while valid && !ready.

  localparam int CW = $clog2(TRIG_TMO + 1);
  localparam logic [CW-1:0] TMO_CNT = CW'(TRIG_TMO);

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] cnt;
  logic          ready_en;
  logic          accept;
  logic          capture;
  logic          timeout;
  logic          fifo_full;
  logic          fifo_empty;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_valid && acc_ready) begin
          accept    = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (norm_trig) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == TMO_CNT) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ready_en      <= 1'b0;
      norm_stb      <= 1'b0;
      norm_acc_data <= '0;
      tmo_err       <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      state    <= state_nxt;
      norm_stb <= accept;
      if (accept) norm_acc_data <= acc_data;
      if (state == ISSUE) cnt <= CW'(1);
      else if (state == WAIT && !capture && !timeout) cnt <= cnt + 1'b1;
      if (timeout) tmo_err <= 1'b1;
    end
  end

  // ready_en keeps acc_ready low on the reset cycle itself, when the state is already IDLE.
  assign acc_ready = ready_en && (state == IDLE) && !fifo_full;
  assign busy      = (state != IDLE);
  assign nn_valid  = !fifo_empty;

`ifdef NORM_SEQ_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk) begin
    if (!rst_n) drop_q <= '0;
    else if (timeout && drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 16'd0;
`endif

  norm_seq_fifo #(
    .DEPTH(FIFO_DEPTH),
    .W    (OUT_W)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (capture),
    .pop  (nn_valid && nn_ready),
    .din  (norm_data),
    .dout (nn_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_norm_sequencer.sv
// Directed bench for norm_sequencer with a behavioural normalizer (data 4, trig 5 edges after norm_stb).
// Expected drop_cnt follows NORM_SEQ_DROP_CNT_EN.
module tb_norm_sequencer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 36;

`ifdef NORM_SEQ_DROP_CNT_EN
  localparam logic [15:0] EXP_DROP = 16'd1;
`else
  localparam logic [15:0] EXP_DROP = 16'd0;
`endif

  localparam logic [IN_W-1:0]  W1 = 64'h0000_1000_0000_2000;
  localparam logic [OUT_W-1:0] E1 = {18'h01000, 18'h02000};
  localparam logic [IN_W-1:0]  WA = 64'h0003_ABCD_0001_1234;
  localparam logic [OUT_W-1:0] EA = {18'h3ABCD, 18'h11234};
  localparam logic [IN_W-1:0]  WB = 64'hFFFC_0001_0002_FFFF;
  localparam logic [OUT_W-1:0] EB = {18'h00001, 18'h2FFFF};
  localparam logic [IN_W-1:0]  WC = 64'h1234_5678_9ABC_DEF0;
  localparam logic [OUT_W-1:0] EC = {18'h05678, 18'h0DEF0};
  localparam logic [IN_W-1:0]  WD = 64'h0002_0000_0001_0000;
  localparam logic [OUT_W-1:0] ED = {18'h20000, 18'h10000};
  localparam logic [IN_W-1:0]  WE = 64'h0000_0ABC_0000_0DEF;
  localparam logic [OUT_W-1:0] EE = {18'h00ABC, 18'h00DEF};

  logic             clk;
  logic             rst_n;
  logic             acc_valid;
  logic             acc_ready;
  logic [IN_W-1:0]  acc_data;
  logic [IN_W-1:0]  norm_acc_data;
  logic             norm_stb;
  logic [OUT_W-1:0] norm_data;
  logic             norm_trig;
  logic             nn_valid;
  logic             nn_ready;
  logic [OUT_W-1:0] nn_data;
  logic             busy;
  logic             tmo_err;
  logic [15:0]      drop_cnt;

  norm_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .acc_valid    (acc_valid),
    .acc_ready    (acc_ready),
    .acc_data     (acc_data),
    .norm_acc_data(norm_acc_data),
    .norm_stb     (norm_stb),
    .norm_data    (norm_data),
    .norm_trig    (norm_trig),
    .nn_valid     (nn_valid),
    .nn_ready     (nn_ready),
    .nn_data      (nn_data),
    .busy         (busy),
    .tmo_err      (tmo_err),
    .drop_cnt     (drop_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [OUT_W-1:0] exp_q[$];

  // normalizer model: hist[k] holds norm_stb as seen k+1 negedges ago
  logic [4:0] hist      = '0;
  logic       trig_m    = 1'b0;
  logic       spur_trig = 1'b0;
  logic       model_en  = 1'b1;

  assign norm_trig = trig_m | spur_trig;

  initial norm_data = '0;

  always @(negedge clk) begin
    trig_m = hist[4] & model_en;
    if (hist[3]) norm_data = {norm_acc_data[49:32], norm_acc_data[17:0]};
    hist = {hist[3:0], norm_stb};
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Leaves acc_valid high on return (at the first negedge after acceptance).
  task automatic send_word(input logic [IN_W-1:0] w, input logic [OUT_W-1:0] e, input bit expect_out);
    int k = 0;
    acc_valid = 1'b1;
    acc_data  = w;
    while (!acc_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("accept", 64'(k < 200), 64'd1);
    @(negedge clk);
    if (expect_out) exp_q.push_back(e);
  endtask

  task automatic wait_nn(input string tag);
    int k = 0;
    while (!nn_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_valid"}, 64'(nn_valid), 64'd1);
    if (exp_q.size() == 0) check({tag, "_queue"}, 64'd0, 64'd1);
    else check(tag, 64'(nn_data), 64'(exp_q.pop_front()));
    nn_ready = 1'b1;
    @(negedge clk);
    nn_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("idle_tmo", 64'(k < 100), 64'd1);
  endtask

  initial begin
    bit stall_ok;
    int k;
    rst_n = 1'b0; acc_valid = 1'b0; acc_data = '0; nn_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_acc_ready", 64'(acc_ready), 64'd0);
    check("rst_norm_stb", 64'(norm_stb), 64'd0);
    check("rst_nn_valid", 64'(nn_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_tmo_err", 64'(tmo_err), 64'd0);
    check("rst_norm_acc_data", norm_acc_data, 64'd0);
    check("rst_nn_data", 64'(nn_data), 64'd0);
    check("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_acc_ready", 64'(acc_ready), 64'd1);

    // single sample latency
    send_word(W1, E1, 1'b1);
    acc_valid = 1'b0;
    check("t1_stb", 64'(norm_stb), 64'd1);
    check("t1_busy", 64'(busy), 64'd1);
    check("t1_acc_ready", 64'(acc_ready), 64'd0);
    check("t1_hold", norm_acc_data, W1);
    @(negedge clk);
    check("t1_stb_1cyc", 64'(norm_stb), 64'd0);
    repeat (4) @(negedge clk);
    check("t1_nn_valid_early", 64'(nn_valid), 64'd0);
    @(negedge clk);
    check("t1_nn_valid_6", 64'(nn_valid), 64'd1);
    check("t1_nn_data_hand", 64'(nn_data), 64'(E1));
    wait_nn("t1_data");

    // back-to-back with NN stalled: two accepted, third waits
    send_word(WA, EA, 1'b1);
    send_word(WB, EB, 1'b1);
    wait_idle();
    acc_data = WC;
    stall_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (acc_ready !== 1'b0) stall_ok = 1'b0;
      @(negedge clk);
    end
    check("t2_stall", 64'(stall_ok), 64'd1);
    check("t2_busy_stalled", 64'(busy), 64'd0);
    nn_ready = 1'b1;
    check("t2_head_a", 64'(nn_data), 64'(exp_q.pop_front()));
    @(negedge clk);
    check("t2_head_b", 64'(nn_data), 64'(exp_q.pop_front()));
    check("t2_ready_again", 64'(acc_ready), 64'd1);
    @(negedge clk);
    nn_ready = 1'b0;
    acc_valid = 1'b0;
    exp_q.push_back(EC);
    check("t2_c_accepted", 64'(busy), 64'd1);
    wait_nn("t2_c");

    // pop and capture on the same edge
    send_word(WD, ED, 1'b1);
    acc_valid = 1'b0;
    wait_idle();
    send_word(WE, EE, 1'b1);
    acc_valid = 1'b0;
    wait_idle();
    check("t4_full", 64'(acc_ready), 64'd0);
    nn_ready = 1'b1;
    check("t4_head_d", 64'(nn_data), 64'(exp_q.pop_front()));
    @(negedge clk);
    nn_ready = 1'b0;
    send_word(W1, E1, 1'b1);
    acc_valid = 1'b0;
    repeat (5) @(negedge clk);
    nn_ready = 1'b1;
    check("t4_head_e", 64'(nn_data), 64'(exp_q.pop_front()));
    @(negedge clk);
    nn_ready = 1'b0;
    check("t4_valid_kept", 64'(nn_valid), 64'd1);
    check("t4_not_full", 64'(acc_ready), 64'd1);
    wait_nn("t4_new");
    check("t4_empty", 64'(nn_valid), 64'd0);

    // trigger timeout
    model_en = 1'b0;
    send_word(WC, EC, 1'b0);
    acc_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("t3_busy_n15", 64'(busy), 64'd1);
    check("t3_tmo_early", 64'(tmo_err), 64'd0);
    @(negedge clk);
    check("t3_busy_n16", 64'(busy), 64'd0);
    check("t3_tmo_err", 64'(tmo_err), 64'd1);
    check("t3_no_push", 64'(nn_valid), 64'd0);
    check("t3_drop_cnt", 64'(drop_cnt), 64'(EXP_DROP));
    model_en = 1'b1;
    send_word(WB, EB, 1'b1);
    acc_valid = 1'b0;
    wait_nn("t3_next");
    check("t3_tmo_sticky", 64'(tmo_err), 64'd1);

    // reset during WAIT, late trigger must be ignored
    send_word(WA, EA, 1'b0);
    acc_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_in_wait", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_acc_ready", 64'(acc_ready), 64'd0);
    check("t5_norm_acc_data", norm_acc_data, 64'd0);
    check("t5_tmo_err", 64'(tmo_err), 64'd0);
    check("t5_drop_cnt", 64'(drop_cnt), 64'd0);
    check("t5_nn_data", 64'(nn_data), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_late_trig", 64'(nn_valid), 64'd0);
    check("t5_no_err", 64'(tmo_err), 64'd0);

    // spurious trigger in IDLE, then hold checked every WAIT cycle
    spur_trig = 1'b1;
    @(negedge clk);
    spur_trig = 1'b0;
    @(negedge clk);
    check("t6_no_push", 64'(nn_valid), 64'd0);
    check("t6_no_err", 64'(tmo_err), 64'd0);
    check("t6_idle", 64'(busy), 64'd0);
    send_word(WE, EE, 1'b1);
    acc_data  = WD;
    acc_valid = 1'b0;
    k = 0;
    while (busy && k < 20) begin
      check("t6_hold", norm_acc_data, WE);
      @(negedge clk);
      k++;
    end
    wait_nn("t6_data");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
